// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: transaction, state and byte-enable definitions for the fetch/data memory arbiter
package mem_port_arbiter_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } mem_req_t;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and backend handshake signals; slave = arbiter, master = pipeline plus backend
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ready, mem_rdata,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_ready, mem_rdata,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data ports; ARB_STARVE_GUARD_EN adds a fetch anti-starvation guard
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input logic              clk,
    input logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t state_q, state_d;
    mem_req_t   req_q, req_d;
    logic       valid_q, valid_d;
    logic       force_i;

    // grant selection in IDLE, completion handling while busy
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && !force_i) begin
                    req_d   = '{addr: bus.dm_addr, wdata: bus.dm_wdata,
                                wstrb: bus.dm_we ? bus.dm_wstrb : WSTRB_NONE, we: bus.dm_we};
                    valid_d = 1'b1;
                    state_d = BUSY_D;
                end else if (bus.if_req) begin
                    req_d   = '{addr: bus.if_addr, wdata: req_q.wdata, wstrb: WSTRB_NONE, we: 1'b0};
                    valid_d = 1'b1;
                    state_d = BUSY_I;
                end else begin
                    valid_d = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // state and held transaction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] streak_q;

    assign force_i = bus.if_req && (streak_q == 3'(STARVE_LIMIT));

    // counts consecutive data grants made while a fetch is waiting
    always_ff @(posedge clk) begin
        if (reset || !bus.if_req)
            streak_q <= '0;
        else if (state_q == IDLE && state_d == BUSY_I)
            streak_q <= '0;
        else if (state_q == IDLE && state_d == BUSY_D)
            streak_q <= streak_q + 3'd1;
    end
`else
    logic unused_limit;

    assign force_i      = 1'b0;
    assign unused_limit = |STARVE_LIMIT;
`endif

    assign bus.mem_valid = valid_q;
    assign bus.mem_we    = req_q.we;
    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_wstrb = req_q.wstrb;
    assign bus.if_ready  = (state_q == BUSY_I) && bus.mem_ready;
    assign bus.dm_ready  = (state_q == BUSY_D) && bus.mem_ready;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.dm_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus a sustained-contention sequence for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dwstrb;
        logic        mrdy;
        logic [31:0] mrdata;
        logic [71:0] exp;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t tbl [17];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [71:0] ex(logic v, logic we, logic [31:0] a, logic [31:0] wd,
                                       logic [3:0] ws, logic ir, logic dr);
        return {v, we, a, wd, ws, ir, dr};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        bus.if_req    = v.ireq;
        bus.if_addr   = v.iaddr;
        bus.dm_req    = v.dreq;
        bus.dm_we     = v.dwe;
        bus.dm_addr   = v.daddr;
        bus.dm_wdata  = v.dwdata;
        bus.dm_wstrb  = v.dwstrb;
        bus.mem_ready = v.mrdy;
        bus.mem_rdata = v.mrdata;
    endtask

    function automatic logic [71:0] observed();
        return {bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                bus.if_ready, bus.dm_ready};
    endfunction

    initial begin
        logic [9:0] seq;
        logic [9:0] exp_seq;
        int         n;
        logic       both;
        tests = 0;
        fails = 0;
        tbl[0]  = '{0, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        ex(0, 0, 32'h0,    32'h0,        4'h0, 0, 0)};
        tbl[1]  = '{0, 1, 32'h100, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h00500093, ex(1, 0, 32'h100,  32'h0,        4'h0, 1, 0)};
        tbl[2]  = '{0, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h12345678, ex(0, 0, 32'h100,  32'h0,        4'h0, 0, 0)};
        tbl[3]  = '{0, 0, 32'h0,   0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        ex(0, 0, 32'h100,  32'h0,        4'h0, 0, 0)};
        tbl[4]  = '{0, 0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        ex(0, 0, 32'h100,  32'h0,        4'h0, 0, 0)};
        tbl[5]  = '{0, 0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        ex(1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0)};
        tbl[6]  = '{0, 0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        ex(1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0)};
        tbl[7]  = '{0, 0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 32'h0,        ex(1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0)};
        tbl[8]  = '{0, 0, 32'h0,   1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 1, 32'h0BADF00D, ex(1, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 1)};
        tbl[9]  = '{0, 1, 32'h200, 1, 0, 32'h3000, 32'h0,        4'hF, 0, 32'h0,        ex(0, 1, 32'h2004, 32'hDEADBEEF, 4'h3, 0, 0)};
        tbl[10] = '{0, 1, 32'h200, 1, 0, 32'h3000, 32'h0,        4'hF, 1, 32'hCAFEF00D, ex(1, 0, 32'h3000, 32'h0,        4'h0, 0, 1)};
        tbl[11] = '{0, 1, 32'h200, 0, 0, 32'h0,    32'h0,        4'h0, 0, 32'h0,        ex(0, 0, 32'h3000, 32'h0,        4'h0, 0, 0)};
        tbl[12] = '{0, 1, 32'h200, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h00A00113, ex(1, 0, 32'h200,  32'h0,        4'h0, 1, 0)};
        tbl[13] = '{0, 0, 32'h0,   1, 0, 32'h4000, 32'h0,        4'h0, 0, 32'h0,        ex(0, 0, 32'h200,  32'h0,        4'h0, 0, 0)};
        tbl[14] = '{1, 0, 32'h0,   1, 0, 32'h4000, 32'h0,        4'h0, 0, 32'h0,        ex(1, 0, 32'h4000, 32'h0,        4'h0, 0, 0)};
        tbl[15] = '{0, 1, 32'h300, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h55555555, ex(0, 0, 32'h0,    32'h0,        4'h0, 0, 0)};
        tbl[16] = '{0, 1, 32'h300, 0, 0, 32'h0,    32'h0,        4'h0, 1, 32'h11111111, ex(1, 0, 32'h300,  32'h0,        4'h0, 1, 0)};

        drive('{1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 72'h0});
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d", i), observed(), tbl[i].exp);
            if (tbl[i].exp[1])
                chk($sformatf("vec%0d_if_rdata", i), {40'h0, bus.if_rdata}, {40'h0, tbl[i].mrdata});
            if (tbl[i].exp[0])
                chk($sformatf("vec%0d_dm_rdata", i), {40'h0, bus.dm_rdata}, {40'h0, tbl[i].mrdata});
        end

        @(negedge clk);
        drive('{0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 72'h0});
        @(negedge clk);
        drive('{0, 1, 32'h400, 1, 0, 32'h5000, 32'h0, 4'h0, 1, 32'h77777777, 72'h0});
        seq  = '0;
        n    = 0;
        both = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (bus.if_ready && bus.dm_ready) both = 1'b1;
            if ((bus.if_ready || bus.dm_ready) && n < 10) begin
                seq[n] = bus.if_ready;
                n++;
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        exp_seq = 10'b10000_10000;
`else
        exp_seq = 10'b00000_00000;
`endif
        chk("contention_completions", 72'(n), 72'd10);
        chk("contention_grant_order", {62'h0, seq}, {62'h0, exp_seq});
        chk("ready_exclusive", {71'h0, both}, 72'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
